// File: rtl/z2_slave_sequencer.sv
// Zorro II slave-cycle sequencer: strobe synchronisers, lowest-index slave arbitration,
// registered DTACK/OVR/BERR requests with bus timeout and early abort on AS release.
module z2_slave_sequencer #(
    parameter int                    NUM_SLAVES     = 5,
    parameter int                    SYNC_STAGES    = 2,
    parameter int                    TIMEOUT_CYCLES = 255,
    parameter logic [NUM_SLAVES-1:0] DTACK_MASK     = '1,
    parameter logic [NUM_SLAVES-1:0] OVR_MASK       = '1
) (
    input  logic                  MEMCLK,
    input  logic                  RESET,
    input  logic                  AS_n,
    input  logic                  UDS_n,
    input  logic                  LDS_n,
    input  logic                  RW,
    input  logic [NUM_SLAVES-1:0] slave_hit,
    input  logic [NUM_SLAVES-1:0] slave_ack,
    output logic                  as_sync,
    output logic                  uds_sync,
    output logic                  lds_sync,
    output logic                  rw_sync,
    output logic [1:0]            z2_state,
    output logic [NUM_SLAVES-1:0] grant,
    output logic                  dtack,
    output logic                  ovr,
    output logic                  berr,
    output logic                  timeout
);

    localparam int CW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_END   = 2'd3
    } state_t;

    state_t                  state, state_n;
    logic [NUM_SLAVES-1:0]   grant_n;
    logic                    dtack_n, ovr_n, berr_n, timeout_n;
    logic [CW-1:0]           cnt;
    logic                    tmo_hit;
    logic [NUM_SLAVES-1:0]   hit_lowest;
    logic [SYNC_STAGES-1:0]  as_sr, uds_sr, lds_sr, rw_sr;

    always_ff @(posedge MEMCLK or posedge RESET) begin
        if (RESET) begin
            as_sr  <= '1;
            uds_sr <= '1;
            lds_sr <= '1;
            rw_sr  <= '1;
        end else begin
            as_sr  <= {as_sr[SYNC_STAGES-2:0], AS_n};
            uds_sr <= {uds_sr[SYNC_STAGES-2:0], UDS_n};
            lds_sr <= {lds_sr[SYNC_STAGES-2:0], LDS_n};
            rw_sr  <= {rw_sr[SYNC_STAGES-2:0], RW};
        end
    end

    assign as_sync  = as_sr[SYNC_STAGES-1];
    assign uds_sync = uds_sr[SYNC_STAGES-1];
    assign lds_sync = lds_sr[SYNC_STAGES-1];
    assign rw_sync  = rw_sr[SYNC_STAGES-1];
    assign z2_state = state;

    // Two's-complement trick isolates the lowest set hit bit.
    assign hit_lowest = slave_hit & (~slave_hit + NUM_SLAVES'(1));

    // Counter saturates; the compare against TIMEOUT-1 fires on the edge it would reach TIMEOUT.
    assign tmo_hit = (TIMEOUT_CYCLES != 0) && (cnt == TMO_LAST);

    always_ff @(posedge MEMCLK or posedge RESET) begin
        if (RESET) begin
            cnt <= '0;
        end else if (state == S_IDLE) begin
            cnt <= '0;
        end else if (state != S_END && cnt != '1) begin
            cnt <= cnt + CW'(1);
        end
    end

    always_ff @(posedge MEMCLK or posedge RESET) begin
        if (RESET) begin
            state   <= S_IDLE;
            grant   <= '0;
            dtack   <= 1'b0;
            ovr     <= 1'b0;
            berr    <= 1'b0;
            timeout <= 1'b0;
        end else begin
            state   <= state_n;
            grant   <= grant_n;
            dtack   <= dtack_n;
            ovr     <= ovr_n;
            berr    <= berr_n;
            timeout <= timeout_n;
        end
    end

    always_comb begin
        state_n   = state;
        grant_n   = grant;
        dtack_n   = dtack;
        berr_n    = berr;
        timeout_n = 1'b0;
        case (state)
            S_IDLE: begin
                dtack_n = 1'b0;
                berr_n  = 1'b0;
                grant_n = '0;
                if (!as_sync && slave_hit != '0) begin
                    state_n = S_START;
                    grant_n = hit_lowest;
                end
            end
            S_START: begin
                if (as_sync) begin
                    state_n = S_IDLE;
                    grant_n = '0;
                end else if (tmo_hit) begin
                    state_n   = S_END;
                    berr_n    = 1'b1;
                    timeout_n = 1'b1;
                end else if (!uds_sync || !lds_sync) begin
                    state_n = S_DATA;
                end
            end
            S_DATA: begin
                if (as_sync) begin
                    state_n = S_IDLE;
                    grant_n = '0;
                end else if ((slave_ack & grant) != '0) begin
                    state_n = S_END;
                    dtack_n = (grant & DTACK_MASK) != '0;
                end else if (tmo_hit) begin
                    state_n   = S_END;
                    berr_n    = 1'b1;
                    timeout_n = 1'b1;
                end
            end
            S_END: begin
                if (as_sync) begin
                    state_n = S_IDLE;
                    grant_n = '0;
                    dtack_n = 1'b0;
                    berr_n  = 1'b0;
                end
            end
            default: state_n = S_IDLE;
        endcase
        ovr_n = (state_n != S_IDLE) && ((grant_n & OVR_MASK) != '0);
    end

endmodule
